// File: rtl/regfile_wq_pkg.sv
// Shared types for the register-file write queue.
// Provides entry layout, default widths and the x0 constant.
package regfile_wq_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  localparam logic [ADDR_W_DEF-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } wq_entry_t;

endpackage

// File: rtl/regfile_wq_match.sv
// Forwarding lookup over the queued entries (head..tail-1).
// Ports: entries_i, head_i, count_i, qaddr_i in; hit_o, data_o out.
module regfile_wq_match
  import regfile_wq_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  wq_entry_t [DEPTH-1:0]  entries_i,
  input  logic [PW-1:0]          head_i,
  input  logic [CW-1:0]          count_i,
  input  logic [ADDR_W_DEF-1:0]  qaddr_i,
  output logic                   hit_o,
  output logic [DATA_W_DEF-1:0]  data_o
);

  logic [PW-1:0] idx;

  // Scan oldest to youngest; a later match overrides,
  // so the youngest matching entry wins.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_i + PW'(i);
      if (CW'(i) < count_i &&
          entries_i[idx].addr == qaddr_i &&
          qaddr_i != REG_ZERO) begin
        hit_o  = 1'b1;
        data_o = entries_i[idx].data;
      end
    end
  end

endmodule

// File: rtl/regfile_write_queue.sv
// Buffered writer for the register file WE3/A3/WD3 port.
// Ports: in_valid/in_ready/in_addr/in_data request side,
//   drain_en, we3/a3/wd3 write port, q_addrN/hitN/fwd_dataN
//   lookups, count/empty/full status.
module regfile_write_queue
  import regfile_wq_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              drain_en,
  output logic              we3,
  output logic [ADDR_W-1:0] a3,
  output logic [DATA_W-1:0] wd3,
  input  logic [ADDR_W-1:0] q_addr1,
  input  logic [ADDR_W-1:0] q_addr2,
  output logic              hit1,
  output logic              hit2,
  output logic [DATA_W-1:0] fwd_data1,
  output logic [DATA_W-1:0] fwd_data2,
  output logic [CW-1:0]     count,
  output logic              empty,
  output logic              full
);

  wq_entry_t [DEPTH-1:0] mem_q;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;
  wq_entry_t     head_e;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  // Registered-state only: no path from drain_en.
  assign in_ready = !full;
  assign push     = in_valid && in_ready &&
                    (in_addr != REG_ZERO);
  assign pop      = drain_en && !empty;
  assign count    = count_q;

  assign head_e = mem_q[head_q];
  assign we3    = pop;
  assign a3     = empty ? '0 : head_e.addr;
  assign wd3    = empty ? '0 : head_e.data;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop)  head_d = head_q + PW'(1);
    if (push) tail_d = tail_q + PW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload needs no reset: it is only observed
  // through count-qualified reads.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[tail_q] <= '{addr: in_addr, data: in_data};
    end
  end

  regfile_wq_match #(.DEPTH(DEPTH)) u_match1 (
    .entries_i (mem_q),
    .head_i    (head_q),
    .count_i   (count_q),
    .qaddr_i   (q_addr1),
    .hit_o     (hit1),
    .data_o    (fwd_data1)
  );

  regfile_wq_match #(.DEPTH(DEPTH)) u_match2 (
    .entries_i (mem_q),
    .head_i    (head_q),
    .count_i   (count_q),
    .qaddr_i   (q_addr2),
    .hit_o     (hit2),
    .data_o    (fwd_data2)
  );

endmodule

// File: doc/regfile_write_queue.md
# regfile_write_queue

Buffered writer for the processor's 32×32 register file write port. Accepts writeback requests from execute/load units over a valid/ready handshake, queues up to DEPTH of them, and drains one per cycle onto the register file's WE3/A3/WD3 port. Provides two forwarding lookups so decode can read values that are still queued. Writes to x0 are discarded, so the register file's x0 never changes.

## Interface
- DEPTH, 4, queue entries; power of two, ≥2
- DATA_W, 32, data width
- ADDR_W, 5, register address width
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  write request valid
- in_ready  out  1  queue can accept a request this cycle
- in_addr  in  ADDR_W  destination register
- in_data  in  DATA_W  write data
- drain_en  in  1  allow the head entry to be written to the register file this cycle
- we3  out  1  register file write enable
- a3  out  ADDR_W  register file write address
- wd3  out  DATA_W  register file write data
- q_addr1, q_addr2  in  ADDR_W  forwarding lookup addresses (decode's A1/A2)
- hit1, hit2  out  1  a queued entry targets q_addrN
- fwd_data1, fwd_data2  out  DATA_W  data of the youngest matching entry; 0 on miss
- count  out  $clog2(DEPTH)+1  occupancy
- empty, full  out  1  count==0, count==DEPTH

## Operation
- Storage: circular buffer of {addr, data} entries, plus head/tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus a count register.
- Push: in_valid && in_ready && in_addr!=0 writes the entry at tail, then tail+1.
- Discard: in_valid && in_ready && in_addr==0 completes the handshake and changes no state.
- in_ready = !full. It does not depend on a pop in the same cycle, so there is no combinational path from drain_en to in_ready.
- Pop: drain_en && !empty advances head.
- Write-port outputs:
  - we3 = drain_en && !empty.
  - a3/wd3 = head entry when !empty; 0 when empty.
- Count update: push and pop in the same cycle leave count unchanged. A push alone increments count; a pop alone decrements it.
- Lookup, evaluated independently for each port N:
  - Scan valid entries, from head to tail-1.
  - hitN = some entry has addr==q_addrN, and q_addrN!=0.
  - fwd_dataN = data of the youngest such entry (closest to tail).
  - Lookups are combinational, over the registered queue state only. Neither the entry being pushed this cycle nor the pop in progress is excluded.
- Several pending writes to one register are kept in order and drained in FIFO order. The register file ends with the last value.

## Timing
- Reset, asynchronous assert: head=tail=0 and count=0. As a result, empty=1, full=0, in_ready=1, we3=0, a3=0, wd3=0, hit1=hit2=0, fwd_data1=fwd_data2=0.
- Reset mid-operation: all queued writes are lost and no partial write is issued. we3 drops in the same cycle rst asserts.
- Minimum latency:
  - Request accepted at edge N into an empty queue.
  - The entry appears on we3/a3/wd3 during cycle N..N+1 (if drain_en=1).
  - The register file captures it at edge N+1.
- Throughput: one push and one pop per cycle sustained. The queue never over- or under-flows.
- Full: with full=1, a request is held (in_ready=0) even if a pop happens in that cycle. It is accepted on the following cycle.
- drain_en=0: we3=0, entries are retained, and count can still grow until full.
- Pointer wrap: tail DEPTH-1→0 and head DEPTH-1→0 work with no gap or duplication.

## Structure
- Shared package `regfile_wq_pkg`:
  - localparams for DATA_W/ADDR_W defaults
  - typedef `wq_entry_t` {addr, data}
  - constant `REG_ZERO`=0
- Sub-module `regfile_wq_match`:
  - Inputs: entry array, head, count, query address.
  - Outputs: hit and youngest data.
  - Instantiated twice, once per lookup port.

## Test plan
- Reset, then push x5←0x14 with drain_en=1:
  - in_ready=1.
  - The next cycle shows we3=1, a3=5, wd3=0x14.
  - The following cycle shows we3=0 and empty=1.
- drain_en=0, push x1←0xA, x2←0xB, x3←0xC, x4←0xD:
  - full=1, in_ready=0.
  - A fifth push x6←0xE is held until drain_en=1.
  - Drain order is 1,2,3,4,6.
- drain_en=0, push x7←0x11 then x7←0x22, with q_addr1=7:
  - hit1=1, fwd_data1=0x22.
  - After the full drain, the register file's x7 holds 0x22 and hit1=0.
- Push x0←0xFFFF_FFFF:
  - in_ready=1 and the handshake completes.
  - count stays 0 and we3 never asserts.
  - q_addr2=0 gives hit2=0.
- Continuous push/pop for 3×DEPTH cycles with incrementing data:
  - count stays constant.
  - The data at a3/wd3 matches the push order across pointer wrap.
- Queue holding 3 entries, rst pulsed mid-cycle:
  - we3=0 immediately, count=0, empty=1.
  - No queued entry is written after rst deasserts.
